// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Holds default bus widths, FSM state encoding and requester indices.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic REQ_0 = 1'b0;
    localparam logic REQ_1 = 1'b1;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_arbiter_2p_if.sv
// Client-side bus of the RAM arbiter: two req/gnt/done requesters plus read data.
// master = client blocks, slave = arbiter.
interface ram_arbiter_2p_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, done0, done1, rdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, done0, done1, rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: a tie goes to the requester
// that did not own the RAM last.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       winner,
    output logic       valid
);

    // Winner selection from the request pair and previous owner
    always_comb begin
        winner = REQ_0;
        valid  = |req;
        case (req)
            2'b01:   winner = REQ_0;
            2'b10:   winner = REQ_1;
            2'b11:   winner = ~last_owner;
            default: winner = REQ_0;
        endcase
    end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Shares one single-port asynchronous-read RAM between two requesters.
// Every RAM-side and client-side output comes straight from a register.
module ram_arbiter_2p
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    ram_arbiter_2p_if.slave   bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_write,
    output logic              ram_cs,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_t            state_r, state_s;
    logic              owner_r, owner_s;
    logic              last_owner_r, last_owner_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [ADDR_W-1:0] ram_addr_r, ram_addr_s;
    logic [DATA_W-1:0] ram_din_r, ram_din_s;
    logic              ram_write_r, ram_write_s;
    logic              ram_cs_r, ram_cs_s;
    logic [DATA_W-1:0] rdata_r, rdata_s;
    logic [1:0]        gnt_r, gnt_s;
    logic [1:0]        done_r, done_s;
    logic              winner_s;
    logic              pick_valid_s;

    rr_arb2 u_rr_arb2 (
        .req        ({bus.req1, bus.req0}),
        .last_owner (last_owner_r),
        .winner     (winner_s),
        .valid      (pick_valid_s)
    );

    // Next-state and next-output logic of the access sequencer
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        last_owner_s = last_owner_r;
        cnt_s        = cnt_r;
        ram_addr_s   = ram_addr_r;
        ram_din_s    = ram_din_r;
        ram_write_s  = ram_write_r;
        ram_cs_s     = ram_cs_r;
        rdata_s      = rdata_r;
        gnt_s        = 2'b00;
        done_s       = 2'b00;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    ram_addr_s   = (winner_s == REQ_1) ? bus.addr1  : bus.addr0;
                    ram_din_s    = (winner_s == REQ_1) ? bus.wdata1 : bus.wdata0;
                    ram_write_s  = (winner_s == REQ_1) ? bus.we1    : bus.we0;
                    ram_cs_s     = 1'b1;
                    owner_s      = winner_s;
                    last_owner_s = winner_s;
                    cnt_s        = CNT_LOAD;
                    gnt_s        = owner_onehot(winner_s);
                    state_s      = ST_ACCESS;
                end else begin
                    ram_cs_s    = 1'b0;
                    ram_write_s = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    // ram_write still carries the latched direction here
                    if (!ram_write_r) begin
                        rdata_s = ram_dout;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    ram_cs_s    = 1'b0;
                    ram_write_s = 1'b0;
                    done_s      = owner_onehot(owner_r);
                    state_s     = ST_DONE;
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                ram_cs_s    = 1'b0;
                ram_write_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the RAM strobes at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= REQ_0;
            last_owner_r <= REQ_1;
            cnt_r        <= {CNT_W{1'b0}};
            ram_addr_r   <= {ADDR_W{1'b0}};
            ram_din_r    <= {DATA_W{1'b0}};
            ram_write_r  <= 1'b0;
            ram_cs_r     <= 1'b0;
            rdata_r      <= {DATA_W{1'b0}};
            gnt_r        <= 2'b00;
            done_r       <= 2'b00;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            last_owner_r <= last_owner_s;
            cnt_r        <= cnt_s;
            ram_addr_r   <= ram_addr_s;
            ram_din_r    <= ram_din_s;
            ram_write_r  <= ram_write_s;
            ram_cs_r     <= ram_cs_s;
            rdata_r      <= rdata_s;
            gnt_r        <= gnt_s;
            done_r       <= done_s;
        end
    end

    assign ram_addr  = ram_addr_r;
    assign ram_din   = ram_din_r;
    assign ram_write = ram_write_r;
    assign ram_cs    = ram_cs_r;
    assign bus.gnt0  = gnt_r[0];
    assign bus.gnt1  = gnt_r[1];
    assign bus.done0 = done_r[0];
    assign bus.done1 = done_r[1];
    assign bus.rdata = rdata_r;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Bench for ram_arbiter_2p: two instances (WAIT_CYCLES 1 and 3) each with a RAM model,
// driven by directed and random requesters and checked against a transaction-level model.
module tb_ram_arbiter_2p;

    localparam int AW = 10;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic [1:0]    req_v     [2];
    logic [1:0]    we_v      [2];
    logic [AW-1:0] addr_v    [2][2];
    logic [DW-1:0] wdata_v   [2][2];
    logic [1:0]    gnt_v     [2];
    logic [1:0]    done_v    [2];
    logic [DW-1:0] rdata_v   [2];
    logic [AW-1:0] ram_addr_v  [2];
    logic [DW-1:0] ram_din_v   [2];
    logic [DW-1:0] ram_dout_v  [2];
    logic          ram_write_v [2];
    logic          ram_cs_v    [2];

    for (genvar d = 0; d < 2; d++) begin : g_dut
        ram_arbiter_2p_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
        logic [DW-1:0] mem [1024];

        assign bus.req0   = req_v[d][0];
        assign bus.req1   = req_v[d][1];
        assign bus.we0    = we_v[d][0];
        assign bus.we1    = we_v[d][1];
        assign bus.addr0  = addr_v[d][0];
        assign bus.addr1  = addr_v[d][1];
        assign bus.wdata0 = wdata_v[d][0];
        assign bus.wdata1 = wdata_v[d][1];
        assign gnt_v[d]   = {bus.gnt1, bus.gnt0};
        assign done_v[d]  = {bus.done1, bus.done0};
        assign rdata_v[d] = bus.rdata;

        ram_arbiter_2p #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES((d == 0) ? 1 : 3)) dut (
            .clk       (clk),
            .rst       (rst),
            .bus       (bus),
            .ram_addr  (ram_addr_v[d]),
            .ram_din   (ram_din_v[d]),
            .ram_write (ram_write_v[d]),
            .ram_cs    (ram_cs_v[d]),
            .ram_dout  (ram_dout_v[d])
        );

        // Single-port RAM: write on clock when write&cs, asynchronous read
        always @(posedge clk) begin
            if (ram_cs_v[d] && ram_write_v[d]) mem[ram_addr_v[d]] <= ram_din_v[d];
        end
        assign ram_dout_v[d] = mem[ram_addr_v[d]];
    end

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int wcfg(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Reference model state
    logic [DW-1:0] ref_mem [2][1024];
    logic [AW-1:0] wlist [$];
    bit            model_last [2];
    logic [1:0]    snap [2];
    int            gcnt [2][2];
    int            cs_cnt [2];
    int            glog [2][$];

    function automatic int rr_model(input logic [1:0] rq, input bit last);
        if (rq == 2'b11) return last ? 0 : 1;
        if (rq[0]) return 0;
        if (rq[1]) return 1;
        return -1;
    endfunction

    // Requests visible at each active edge (none count while in reset)
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) snap[d] = rst ? 2'b00 : req_v[d];
    end

    // Arbitration and one-hot checks on every grant/done
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                model_last[d] = 1'b1;
            end else begin
                if (ram_cs_v[d]) cs_cnt[d]++;
                if (gnt_v[d] != 2'b00) begin
                    int w;
                    w = rr_model(snap[d], model_last[d]);
                    check_eq("gnt_winner", {30'd0, gnt_v[d]}, (w < 0) ? 32'd0 : (32'd1 << w));
                    if (w >= 0) model_last[d] = w[0];
                    if (gnt_v[d][0]) gcnt[d][0]++;
                    if (gnt_v[d][1]) gcnt[d][1]++;
                    glog[d].push_back(gnt_v[d][1] ? 1 : 0);
                end
                if (done_v[d] != 2'b00) check_eq("done_onehot", $countones(done_v[d]), 32'd1);
            end
        end
    end

    // One complete access by requester r of instance d, entered and left on a negedge
    task automatic do_access(input int d, input int r, input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, output int gwait);
        int            k;
        int            cs_seen;
        logic [DW-1:0] exp_rd;
        req_v[d][r]   = 1'b1;
        we_v[d][r]    = we;
        addr_v[d][r]  = a;
        wdata_v[d][r] = wd;
        gwait = 0;
        do begin
            @(negedge clk);
            gwait++;
        end while (!gnt_v[d][r] && gwait < 400);
        check_eq("gnt_seen", {31'd0, gnt_v[d][r]}, 32'd1);
        req_v[d][r]   = 1'b0;
        we_v[d][r]    = 1'($urandom);
        addr_v[d][r]  = AW'($urandom);
        wdata_v[d][r] = DW'($urandom);
        if (!gnt_v[d][r]) return;
        exp_rd = ref_mem[d][a];
        if (we) ref_mem[d][a] = wd;
        check_eq("addr_at_gnt", {22'd0, ram_addr_v[d]}, {22'd0, a});
        check_eq("write_at_gnt", {31'd0, ram_write_v[d]}, {31'd0, we});
        if (we) check_eq("din_at_gnt", {24'd0, ram_din_v[d]}, {24'd0, wd});
        cs_seen = ram_cs_v[d] ? 1 : 0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (!done_v[d][r] && ram_cs_v[d]) begin
                cs_seen++;
                check_eq("addr_stable", {22'd0, ram_addr_v[d]}, {22'd0, a});
                check_eq("write_level", {31'd0, ram_write_v[d]}, {31'd0, we});
            end
        end while (!done_v[d][r] && k < 400);
        check_eq("done_seen", {31'd0, done_v[d][r]}, 32'd1);
        check_eq("done_latency", k, wcfg(d));
        check_eq("cs_cycles", cs_seen, wcfg(d));
        check_eq("cs_off_at_done", {31'd0, ram_cs_v[d]}, 32'd0);
        if (!we) check_eq("rdata", {24'd0, rdata_v[d]}, {24'd0, exp_rd});
    endtask

    task automatic rand_client(input int r);
        int            gw;
        logic          we;
        logic [AW-1:0] a;
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            we = (wlist.size() == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            a  = we ? AW'($urandom_range(0, 1023)) : wlist[$urandom_range(0, wlist.size() - 1)];
            do_access(0, r, we, a, DW'($urandom), gw);
            if (we) wlist.push_back(a);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int gw;
        int start;
        int g0;
        int c0;
        int k;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_v[d] = 2'b00;
            we_v[d]  = 2'b00;
            for (int r = 0; r < 2; r++) begin
                addr_v[d][r]  = '0;
                wdata_v[d][r] = '0;
            end
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_gnt", {30'd0, gnt_v[d]}, 32'd0);
            check_eq("rst_done", {30'd0, done_v[d]}, 32'd0);
            check_eq("rst_cs", {31'd0, ram_cs_v[d]}, 32'd0);
            check_eq("rst_write", {31'd0, ram_write_v[d]}, 32'd0);
            check_eq("rst_rdata", {24'd0, rdata_v[d]}, 32'd0);
            check_eq("rst_addr", {22'd0, ram_addr_v[d]}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Write then read back address 5 on the single-wait instance
        do_access(0, 0, 1'b1, 10'd5, 8'h0A, gw);
        check_eq("first_gnt_wait", gw, 32'd1);
        do_access(0, 1, 1'b0, 10'd5, 8'h00, gw);
        check_eq("rdata_0a", {24'd0, rdata_v[0]}, 32'h0A);
        do_access(0, 0, 1'b1, 10'd1, 8'h11, gw);
        do_access(0, 1, 1'b1, 10'd2, 8'h22, gw);
        wlist.push_back(10'd5);
        wlist.push_back(10'd1);
        wlist.push_back(10'd2);

        // Both requesters held continuously: grants must alternate from 0
        start = glog[0].size();
        fork
            begin
                for (int i = 0; i < 4; i++) do_access(0, 0, 1'b0, 10'd1, 8'h00, gw);
            end
            begin
                for (int i = 0; i < 4; i++) do_access(0, 1, 1'b0, 10'd2, 8'h00, gw);
            end
        join
        check_eq("alt_len", glog[0].size() - start, 32'd8);
        for (int i = 0; i < 8 && start + i < glog[0].size(); i++)
            check_eq("alternate", glog[0][start + i], i % 2);

        // A one-cycle req0 pulse during a busy req1 access is withdrawn
        g0 = gcnt[0][0];
        c0 = cs_cnt[0];
        fork
            do_access(0, 1, 1'b0, 10'd1, 8'h00, gw);
            begin
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!gnt_v[0][1] && k < 400);
                req_v[0][0] = 1'b1;
                we_v[0][0]  = 1'b1;
                addr_v[0][0] = 10'd9;
                @(negedge clk);
                req_v[0][0] = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check_eq("withdraw_no_gnt0", gcnt[0][0] - g0, 32'd0);
        check_eq("withdraw_cs", cs_cnt[0] - c0, 32'd1);

        // Three-cycle wait instance, top address
        do_access(1, 0, 1'b1, 10'd1023, 8'hFE, gw);
        do_access(1, 1, 1'b0, 10'd1023, 8'h00, gw);
        check_eq("rdata_fe", {24'd0, rdata_v[1]}, 32'hFE);

        // Random traffic on the single-wait instance
        fork
            rand_client(0);
            rand_client(1);
        join
        repeat (2) @(negedge clk);

        // Reset in the second ACCESS cycle of a requester-0 write
        req_v[1][0]   = 1'b1;
        we_v[1][0]    = 1'b1;
        addr_v[1][0]  = 10'd7;
        wdata_v[1][0] = 8'h55;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!gnt_v[1][0] && k < 400);
        check_eq("rst_test_gnt", {31'd0, gnt_v[1][0]}, 32'd1);
        req_v[1][0] = 1'b0;
        @(negedge clk);
        check_eq("cs_before_rst", {31'd0, ram_cs_v[1]}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("cs_async_rst", {31'd0, ram_cs_v[1]}, 32'd0);
        check_eq("write_async_rst", {31'd0, ram_write_v[1]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("no_done_after_rst", {30'd0, done_v[1]}, 32'd0);
        end
        start = glog[1].size();
        fork
            do_access(1, 0, 1'b0, 10'd1023, 8'h00, gw);
            do_access(1, 1, 1'b0, 10'd1023, 8'h00, gw);
        join
        check_eq("post_rst_len", glog[1].size() - start, 32'd2);
        if (glog[1].size() >= start + 2) begin
            check_eq("post_rst_first", glog[1][start], 32'd0);
            check_eq("post_rst_second", glog[1][start + 1], 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
